// File: rtl/cube_uart_tx.sv
// Serialises a 26-byte cube-state frame (sync, six face words, XOR checksum) as 8N1 UART.
// All six faces are captured when a frame is accepted; tx is driven straight from a flop.
module cube_uart_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] face_front,
  input  logic [31:0] face_back,
  input  logic [31:0] face_up,
  input  logic [31:0] face_down,
  input  logic [31:0] face_left,
  input  logic [31:0] face_right,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CPB_RAW      = CLK_HZ / BAUD;
  localparam int CLKS_PER_BIT = (CPB_RAW < 2) ? 2 : CPB_RAW;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_BYTE = 5'd25;
  localparam logic [4:0]    LAST_FACE_BYTE = 5'd24;
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [4:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [191:0]    snap_q, snap_d;
  logic [7:0]      csum_q, csum_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            armed_q, armed_d;
  logic            timer_expired;
  logic [7:0]      next_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      snap_q     <= '0;
      csum_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      snap_q     <= snap_d;
      csum_q     <= csum_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
    end
  end

  assign timer_expired = (timer_q == TIMER_MAX);
  // The face snapshot shifts up one byte per load, so its top byte is always the next face byte.
  assign next_byte = (byte_idx_q == LAST_FACE_BYTE) ? csum_q : snap_q[191:184];

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    snap_d     = snap_q;
    csum_d     = csum_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    // A start held across reset release must drop once before it counts.
    armed_d    = armed_q | ~start;

    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          state_d    = START;
          timer_d    = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          shift_d    = SYNC_BYTE;
          csum_d     = '0;
          snap_d     = {face_front, face_back, face_up, face_down, face_left, face_right};
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (timer_expired) begin
          state_d   = DATA;
          timer_d   = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_expired) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_expired) begin
          timer_d = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d    = START;
            tx_d       = 1'b0;
            byte_idx_d = byte_idx_q + 5'd1;
            shift_d    = next_byte;
            if (byte_idx_q != LAST_FACE_BYTE) begin
              snap_d = snap_q << 8;
              csum_d = csum_q ^ next_byte;
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_cube_uart_tx.sv
// Randomised scoreboard bench for cube_uart_tx: a UART line decoder checks every byte
// against frames built by a byte-list model, while a second monitor checks busy/done timing.
module tb_cube_uart_tx;

  localparam int CLK_HZ    = 400;
  localparam int BAUD      = 100;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = 260 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] face_front, face_back, face_up, face_down, face_left, face_right;
  logic        tx, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_count = 0;
  int last_gap = 0;
  logic [7:0] exp_q[$];

  cube_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .face_front(face_front), .face_back(face_back), .face_up(face_up),
    .face_down(face_down), .face_left(face_left), .face_right(face_right),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: sync byte, each face MSB byte first, then XOR of the 24 face bytes.
  task automatic pushFrame(input logic [31:0] fr, bk, up, dn, lf, rt);
    logic [31:0] w[6];
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    w = '{fr, bk, up, dn, lf, rt};
    exp_q.push_back(8'hA5);
    foreach (w[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = w[i][8*k +: 8];
        cs = cs ^ b;
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic applyStimulus(input logic [31:0] fr, bk, up, dn, lf, rt);
    @(negedge clk);
    face_front = fr; face_back = bk; face_up = up;
    face_down = dn; face_left = lf; face_right = rt;
    pushFrame(fr, bk, up, dn, lf, rt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < FRAME_CYC + 200; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(name, got, 1'b1);
  endtask

  task automatic finishFrame(input string name, input int d0, input int frames);
    repeat (2) @(negedge clk);
    checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
    checkOutput({name, "_done_count"}, done_count, d0 + frames);
  endtask

  task automatic runFrame(input string name, input logic [31:0] fr, bk, up, dn, lf, rt);
    int d0;
    d0 = done_count;
    applyStimulus(fr, bk, up, dn, lf, rt);
    waitDone({name, "_done"});
    finishFrame(name, d0, 1);
  endtask

  task automatic rxByte();
    logic [7:0] b;
    bit ab;
    ab = 1'b0;
    repeat (CPB / 2) begin @(negedge clk); if (rst) ab = 1'b1; end
    if (ab) return;
    checkOutput("rx_start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) begin @(negedge clk); if (rst) ab = 1'b1; end
      if (ab) return;
      b[i] = tx;
    end
    repeat (CPB) begin @(negedge clk); if (rst) ab = 1'b1; end
    if (ab) return;
    checkOutput("rx_stop_bit", tx, 1'b1);
    if (exp_q.size() == 0) checkOutput("rx_unexpected_byte", {24'h0, b}, 32'h100);
    else checkOutput("rx_byte", b, exp_q.pop_front());
  endtask

  // Line decoder: a low line while idle marks cycle 0 of a start bit.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) rxByte();
    end
  end

  // Busy/done monitor: frame length, done coincident with busy falling, single-cycle done.
  initial begin
    int busy_len;
    int gap_len;
    bit prev_busy;
    bit prev_done;
    bit aborted;
    busy_len = 0; gap_len = 0; prev_busy = 0; prev_done = 0; aborted = 0;
    forever begin
      @(negedge clk);
      if (rst) aborted = 1'b1;
      if (busy) begin
        if (!prev_busy) begin
          last_gap = gap_len;
          aborted = 1'b0;
        end
        busy_len++;
        gap_len = 0;
      end else begin
        if (prev_busy && !aborted) begin
          checkOutput("busy_length", busy_len, FRAME_CYC);
          checkOutput("done_at_busy_fall", done, 1'b1);
        end
        busy_len = 0;
        gap_len++;
      end
      if (done) begin
        done_count++;
        checkOutput("done_single_cycle", prev_done, 1'b0);
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  initial begin
    #(10 * 60000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int d0;
    logic [31:0] r[6];
    rst = 1'b1; start = 1'b0;
    face_front = '0; face_back = '0; face_up = '0;
    face_down = '0; face_left = '0; face_right = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] directed frame");
    runFrame("directed", 32'h01234567, 32'h89ABCDEF, 0, 0, 0, 0);

    $display("[TB] checksum frame");
    runFrame("checksum", 32'h000000FF, 0, 0, 0, 0, 0);

    $display("[TB] snapshot frame");
    d0 = done_count;
    applyStimulus(32'h13579BDF, $urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (9) @(negedge clk);
    face_front = 32'hFFFFFFFF;
    waitDone("snapshot_done");
    finishFrame("snapshot", d0, 1);

    $display("[TB] start while busy");
    d0 = done_count;
    applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (98) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (399) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    waitDone("busy_start_done");
    finishFrame("busy_start", d0, 1);
    repeat (5) @(negedge clk);
    checkOutput("busy_start_no_queue", busy, 1'b0);

    $display("[TB] back-to-back frames");
    d0 = done_count;
    foreach (r[i]) r[i] = $urandom;
    @(negedge clk);
    face_front = r[0]; face_back = r[1]; face_up = r[2];
    face_down = r[3]; face_left = r[4]; face_right = r[5];
    pushFrame(r[0], r[1], r[2], r[3], r[4], r[5]);
    start = 1'b1;
    @(negedge clk);
    foreach (r[i]) r[i] = $urandom;
    face_front = r[0]; face_back = r[1]; face_up = r[2];
    face_down = r[3]; face_left = r[4]; face_right = r[5];
    pushFrame(r[0], r[1], r[2], r[3], r[4], r[5]);
    waitDone("b2b_first_done");
    checkOutput("b2b_busy_in_done_cycle", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_second_start_bit", tx, 1'b0);
    checkOutput("b2b_second_busy", busy, 1'b1);
    waitDone("b2b_second_done");
    checkOutput("b2b_gap", last_gap, 1);
    finishFrame("b2b", d0, 2);

    $display("[TB] reset mid-frame");
    applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    repeat (290) @(negedge clk);
    d0 = done_count;
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("midreset_tx", tx, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("midreset_done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("held_start_ignored", busy, 1'b0);
    checkOutput("midreset_no_done", done_count, d0);
    start = 1'b0;
    @(negedge clk);
    runFrame("after_reset", $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      runFrame("random", $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
